// File: rtl/display_pkg.sv
// Shared constants for the multiplexed seven-segment display path.
// Segment patterns are active-high, ordered {g,f,e,d,c,b,a}.
package display_pkg;

    localparam int unsigned N_DIGITS = 5;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    typedef enum logic {
        S_GUARD = 1'b0,
        S_ON    = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-high seven-segment decoder.
// Non-BCD nibbles (A-F) render as a dash.
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    always_comb begin
        segs = SEG_DASH;
        case (nibble)
            4'd0:    segs = SEG_0;
            4'd1:    segs = SEG_1;
            4'd2:    segs = SEG_2;
            4'd3:    segs = SEG_3;
            4'd4:    segs = SEG_4;
            4'd5:    segs = SEG_5;
            4'd6:    segs = SEG_6;
            4'd7:    segs = SEG_7;
            4'd8:    segs = SEG_8;
            4'd9:    segs = SEG_9;
            default: segs = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Five-digit multiplexed seven-segment scanner with guard interval and
// optional leading-zero blanking; outputs are registered at pin polarity.
module bcd_display_scan
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD       = 8,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [19:0]         bcd,
    input  logic                load,
    input  logic                blank_zeros,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] an
);

    localparam int unsigned          CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]     CNT_GUARD = CNT_W'(GUARD);
    localparam logic [2:0]           IDX_LAST  = 3'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0]  AN_ONE    = 1;
    localparam logic [6:0]           SEG_IDLE  = {7{ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0]  AN_IDLE   = {N_DIGITS{ACTIVE_LOW}};

    logic [19:0]         val_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;
    state_t              state_q, state_d;
    logic [6:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] an_q, an_d;

    logic [3:0]          nibble;
    logic [6:0]          dec_seg;
    logic [N_DIGITS-1:0] blank;
    logic [6:0]          seg_act;
    logic [N_DIGITS-1:0] an_act;

    // Prescaler, digit index and slot state all advance together, so the
    // state register always agrees with the prescaler value it was derived from.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
        state_d = (cnt_d < CNT_GUARD) ? S_GUARD : S_ON;
    end

    // A digit is blanked when it and every more significant digit is zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blank    = '0;
        for (int k = int'(N_DIGITS) - 1; k >= 1; k--) begin
            zero_run = zero_run & (val_q[4*k +: 4] == 4'd0);
            blank[k] = blank_zeros & zero_run;
        end
    end

    assign nibble = val_q[{idx_q, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .nibble (nibble),
        .segs   (dec_seg)
    );

    always_comb begin
        seg_act = SEG_OFF;
        an_act  = '0;
        if (state_q == S_ON) begin
            an_act  = AN_ONE << idx_q;
            seg_act = blank[idx_q] ? SEG_OFF : dec_seg;
        end
        seg_d = seg_act ^ SEG_IDLE;
        an_d  = an_act ^ AN_IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            val_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= S_GUARD;
            seg_q   <= SEG_IDLE;
            an_q    <= AN_IDLE;
        end else begin
            if (load) begin
                val_q <= bcd;
            end
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Multiplexed seven-segment display driver that sits directly downstream of the binary-to-BCD converter. It captures a 20-bit packed BCD value (5 digits) on a load strobe and time-multiplexes the digits onto a shared segment bus with one-hot digit enables. It applies optional leading-zero blanking and inserts a guard interval between digits to suppress ghosting. It feeds the board's display pins directly.

## Interface
- `N_DIGITS`, 5, number of BCD digits scanned. Fixed to 5 to match the 20-bit input.
- `REFRESH_DIV`, 50000, clock cycles per digit slot. Must be ≥ 2.
- `GUARD`, 8, cycles at the start of each slot with all digits off. Must satisfy 1 ≤ GUARD < REFRESH_DIV.
- `ACTIVE_LOW`, 1, when 1, `seg` and `an` are inverted at the pins (common-anode board).
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `bcd` in 20: packed BCD; digit k is `bcd[4k+3:4k]`; digit 0 is least significant.
- `load` in 1: capture `bcd` at this edge.
- `blank_zeros` in 1: enable leading-zero blanking. Sampled live, not captured.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, registered.
- `an` out 5: one-hot digit enable, bit k = digit k, registered.

## Operation
- Capture register `val[19:0]`:
  - Loads `bcd` on any edge with `load`=1. Otherwise holds.
  - Back-to-back loads are all accepted; the last one wins.
- Prescaler `cnt`:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, digit index `idx` advances 0→1→…→4→0.
- Per-slot FSM, two states:
  - S_GUARD while `cnt` < GUARD. Output: all digits off, all segments off.
  - S_ON while GUARD ≤ `cnt` ≤ REFRESH_DIV-1. Output: `an` bit `idx` on, `seg` = decode of digit `idx`.
- Decode, active-high before polarity:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110.
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Nibbles A–F (invalid BCD) display a dash, 1000000.
- Blanking:
  - When `blank_zeros`=1, digit k≥1 is blanked if digits k..4 of `val` are all zero.
  - A blanked digit outputs seg=0000000 but `an` is still asserted, so the slot timing is unchanged.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - An invalid nibble counts as non-zero.
- Polarity: when ACTIVE_LOW=1, both `seg` and `an` are bitwise inverted at the output registers. All values in this document are stated active-high unless noted.

## Timing
- Reset (async assert):
  - `cnt`=0, `idx`=0, `val`=0.
  - `seg` and `an` go inactive immediately: all ones when ACTIVE_LOW=1, all zeros otherwise.
  - Reset asserted mid-scan aborts the slot with no glitch to an active level.
- Output latency: `seg`/`an` in cycle t reflect `cnt`, `idx`, `val` and `blank_zeros` as of cycle t-1 (one register stage).
  - First cycle after reset release: outputs stay inactive (S_GUARD for `cnt`=0).
- Load to display: a value captured at edge E is visible on the currently lit digit from edge E+1.
- Load coinciding with slot wrap: the new `idx` and the new `val` both take effect together; no mixed frame.
- Full frame = 5·REFRESH_DIV cycles. Each digit is lit for REFRESH_DIV−GUARD cycles per frame.
- At most one `an` bit is ever active. The S_GUARD interval guarantees ≥ GUARD dark cycles between any two different active bits.

## Structure
- Shared package `display_pkg` holds:
  - the segment constants (`SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_OFF`);
  - the state encoding `S_GUARD`/`S_ON`;
  - `N_DIGITS`.
- Sub-module `bcd_to_7seg`: purely combinational, 4-bit nibble in, 7-bit active-high segments out. Instantiated once, fed by a mux selecting digit `idx` of `val`.
- The top level holds the capture register, prescaler, index counter, blanking logic and output registers.

## Test plan
All scenarios use REFRESH_DIV=4, GUARD=1, ACTIVE_LOW=0.

1. Reset check: hold `reset_n`=0, then release → seg=0, an=0 during reset and on the first cycle after release. Then an=00001 with seg=0111111 (digit "0") for 3 cycles.
2. Load `bcd`=0x12345, `blank_zeros`=0 → over one 20-cycle frame:
   - an cycles 00001, 00010, 00100, 01000, 10000;
   - seg shows 5, 4, 3, 2, 1 in that order;
   - every slot has 1 dark cycle first.
3. Load 0x00070 with `blank_zeros`=1 → digits 0 and 1 show 0 and 7. Digits 2–4 have an asserted and seg=0. With `blank_zeros`=0, digits 2–4 show 0.
4. Load 0x0A009 → digit 3 shows the dash (1000000). With `blank_zeros`=1, digit 3 is not blanked; digit 4 is blanked.
5. Assert `load` on the same edge as the slot wrap 0→1 with a new value → the digit-1 slot shows the new value's digit 1. Check that at most one `an` bit is ever set across the whole run.
6. Assert `reset_n` mid-slot while an=00100 → an and seg go to 0 asynchronously, before the next clock edge. `val` reads back 0, so "0" is displayed after release.
